// File: rtl/run_fifo_reader.sv
// run_fifo_reader
// Pops 23-bit words from a run FIFO and turns them into pixel runs, line
// markers and frame markers.
//
// Word format:
//   bit22 = 0 : run, start column = [21:11], end column = [10:0]
//   bit22 = 1 : marker, payload [21:0] = 0 end-of-line, = 1 end-of-frame
//
// Ports:
//   clk, rst_n   - single rising-edge clock, asynchronous active-low reset
//   fifo_empty   - run FIFO empty flag
//   fifo_dout    - run FIFO read word, valid the cycle after fifo_rd_en
//   fifo_rd_en   - run FIFO pop strobe (one cycle, only in FETCH)
//   run_valid    - decoded run available, held until run_ready
//   run_ready    - consumer accepts run
//   run_start    - first pixel column of run
//   run_end      - last pixel column of run
//   run_row      - row index of run
//   line_done    - one-cycle pulse per end-of-line marker
//   frame_done   - one-cycle pulse per end-of-frame marker
//   frame_runs   - runs emitted in the last completed frame
//   bad_word     - one-cycle pulse when a word is discarded
module run_fifo_reader #(
  parameter int unsigned ROW_BITS = 10,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic [22:0]         fifo_dout,
  output logic                fifo_rd_en,
  output logic                run_valid,
  input  logic                run_ready,
  output logic [10:0]         run_start,
  output logic [10:0]         run_end,
  output logic [ROW_BITS-1:0] run_row,
  output logic                line_done,
  output logic                frame_done,
  output logic [CNT_BITS-1:0] frame_runs,
  output logic                bad_word
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EMIT   = 2'd3
  } state_e;

  localparam logic [ROW_BITS-1:0] ROW_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic [10:0]         run_start_q, run_start_d;
  logic [10:0]         run_end_q, run_end_d;
  logic [ROW_BITS-1:0] run_row_q, run_row_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [CNT_BITS-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_BITS-1:0] frame_runs_q, frame_runs_d;
  logic                line_done_q, line_done_d;
  logic                frame_done_q, frame_done_d;
  logic                bad_word_q, bad_word_d;

  // Field views of the word currently presented by the FIFO.
  logic        wordIsMarker;
  logic [10:0] wordStart;
  logic [10:0] wordEnd;
  logic [21:0] wordPayload;

  assign wordIsMarker = fifo_dout[22];
  assign wordStart    = fifo_dout[21:11];
  assign wordEnd      = fifo_dout[10:0];
  assign wordPayload  = fifo_dout[21:0];

  // Next-state and output logic. The word popped in FETCH is only valid
  // during DECODE, so it is classified and captured in that one cycle. The
  // marker/bad pulses are registered, which makes them appear on the cycle
  // after DECODE and keeps them exactly one cycle wide. A run moves to EMIT
  // and holds its fields until the consumer takes it; nothing is popped
  // while a run is outstanding.
  always_comb begin
    state_d      = state_q;
    run_start_d  = run_start_q;
    run_end_d    = run_end_q;
    run_row_d    = run_row_q;
    row_d        = row_q;
    run_cnt_d    = run_cnt_q;
    frame_runs_d = frame_runs_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    bad_word_d   = 1'b0;
    fifo_rd_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        // Guard against a FIFO that drained externally since IDLE.
        if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          fifo_rd_en = 1'b1;
          state_d    = DECODE;
        end
      end

      DECODE: begin
        state_d = IDLE;
        if (!wordIsMarker) begin
          if (wordStart <= wordEnd) begin
            run_start_d = wordStart;
            run_end_d   = wordEnd;
            run_row_d   = row_q;
            state_d     = EMIT;
          end else begin
            bad_word_d = 1'b1;
          end
        end else if (wordPayload == 22'd0) begin
          line_done_d = 1'b1;
          if (row_q != ROW_MAX) begin
            row_d = row_q + ROW_BITS'(1);
          end
        end else if (wordPayload == 22'd1) begin
          frame_done_d = 1'b1;
          frame_runs_d = run_cnt_q;
          run_cnt_d    = '0;
          row_d        = '0;
        end else begin
          bad_word_d = 1'b1;
        end
      end

      EMIT: begin
        if (run_ready) begin
          if (run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + CNT_BITS'(1);
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any popped or pending word
  // by returning to IDLE and clearing every visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      run_start_q  <= '0;
      run_end_q    <= '0;
      run_row_q    <= '0;
      row_q        <= '0;
      run_cnt_q    <= '0;
      frame_runs_q <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      bad_word_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_start_q  <= run_start_d;
      run_end_q    <= run_end_d;
      run_row_q    <= run_row_d;
      row_q        <= row_d;
      run_cnt_q    <= run_cnt_d;
      frame_runs_q <= frame_runs_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      bad_word_q   <= bad_word_d;
    end
  end

  // run_valid comes straight from the state so it falls as soon as reset
  // forces IDLE, without waiting for a clock.
  assign run_valid  = (state_q == EMIT);
  assign run_start  = run_start_q;
  assign run_end    = run_end_q;
  assign run_row    = run_row_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign bad_word   = bad_word_q;
  assign frame_runs = frame_runs_q;

endmodule

// File: doc/run_fifo_reader.md
RUN_FIFO_READER -- requirements
Module: run_fifo_reader

Interface
REQ-001 SHALL have parameter ROW_BITS, default 10, width of the row counter.
REQ-002 SHALL have parameter CNT_BITS, default 16, width of the per-frame run counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fifo_empty  input  1  run FIFO empty flag.
REQ-006 SHALL have port fifo_dout  input  23  run FIFO read word, valid the cycle after fifo_rd_en.
REQ-007 SHALL have port fifo_rd_en  output  1  run FIFO pop strobe.
REQ-008 SHALL have port run_valid  output  1  decoded run available.
REQ-009 SHALL have port run_ready  input  1  consumer accepts run.
REQ-010 SHALL have port run_start  output  11  first pixel column of run.
REQ-011 SHALL have port run_end  output  11  last pixel column of run.
REQ-012 SHALL have port run_row  output  ROW_BITS  row index of run.
REQ-013 SHALL have port line_done  output  1  one-cycle pulse per end-of-line marker.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse per end-of-frame marker.
REQ-015 SHALL have port frame_runs  output  CNT_BITS  runs emitted in last completed frame.
REQ-016 SHALL have port bad_word  output  1  one-cycle pulse when a word is discarded.

Function
REQ-017 SHALL decode word format: bit22=0 -> run, start=bits[21:11], end=bits[10:0]; bit22=1 -> marker, bits[21:0]=0 end-of-line, =1 end-of-frame.
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EMIT.
REQ-019 SHALL in IDLE go to FETCH when fifo_empty=0, else stay.
REQ-020 SHALL in FETCH assert fifo_rd_en for exactly that one cycle and go to DECODE.
REQ-021 SHALL in DECODE register fifo_dout and classify it the same cycle; fifo_rd_en=0.
REQ-022 SHALL on a valid run (start<=end) in DECODE load run_start/run_end/run_row and go to EMIT.
REQ-023 SHALL in EMIT hold run_valid=1 and all run_* outputs stable until run_ready=1; on handshake cycle increment run counter and go to IDLE.
REQ-024 SHALL on end-of-line marker pulse line_done next cycle, increment row counter (saturate at 2^ROW_BITS-1), go to IDLE.
REQ-025 SHALL on end-of-frame marker pulse frame_done next cycle, latch frame_runs=run counter (including no pending run), clear row and run counters, go to IDLE.
REQ-026 SHALL on run with start>end or marker payload not 0/1 pulse bad_word next cycle, change no counters, go to IDLE.
REQ-027 SHALL saturate run counter at 2^CNT_BITS-1.
REQ-028 SHALL never assert fifo_rd_en while fifo_empty=1 or outside FETCH.
REQ-029 SHALL never pop a new word while run_valid=1 (no overlap, max one word per 3 cycles).
REQ-030 SHALL keep line_done, frame_done, bad_word mutually exclusive and each exactly one cycle wide.
REQ-031 SHALL allow run_ready to be high before run_valid; handshake occurs on first EMIT cycle then.

Reset
REQ-032 SHALL on rst_n=0 immediately force state IDLE, fifo_rd_en=0, run_valid=0, line_done=0, frame_done=0, bad_word=0, run_start=0, run_end=0, run_row=0, frame_runs=0, counters=0.
REQ-033 SHALL drop any word already popped or pending in EMIT when reset asserts mid-operation; no output after release until a new FETCH.

Verification
REQ-034 SHALL test single run: FIFO holds {0,5,20}, run_ready=1 -> one rd_en pulse, run_valid with start=5 end=20 row=0 two cycles later, accepted same cycle.
REQ-035 SHALL test backpressure: run_ready=0 for 10 cycles -> run_valid and run_* stable, no further rd_en, then accepted on ready.
REQ-036 SHALL test frame: runs (1,3),(4,9), EOL, run (0,2), EOL, EOF -> rows 0,0,1; two line_done; frame_done with frame_runs=3; next run row=0.
REQ-037 SHALL test bad words: run (9,4) and marker payload 2 -> two bad_word pulses, no run_valid, counters unchanged.
REQ-038 SHALL test reset: assert rst_n=0 during EMIT -> run_valid drops asynchronously, all outputs zero, next frame counts from 0.
REQ-039 SHALL test empty FIFO: fifo_empty=1 held 50 cycles -> fifo_rd_en never asserted.
